imm_gen_pipe: RTL and testbench

- Registered, parametrised RISC-V immediate generator stage with valid/ready handshake on both sides.
- Accepts a fetched instruction word plus a tag.
- Classifies the format (I/S/B/U/J), produces the sign-extended XLEN-bit immediate and an illegal-opcode flag.
- Sits between the fetch buffer and the decode/issue stage; a 2-entry skid buffer gives full throughput under backpressure.

---
 rtl/imm_gen_pkg.sv | 30 +++
 rtl/imm_gen_pipe_decode.sv | 69 ++++++
 rtl/imm_gen_pipe.sv | 121 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the immediate generator stage.
package imm_gen_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned FMT_W   = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R    = 3'd6,
    FMT_Z    = 3'd7
  } imm_fmt_e;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RISC-V immediate decode: format, sign-extended immediate, illegal flag.
// IMM_GEN_ZICSR_EN enables SYSTEM (CSR) decoding; otherwise SYSTEM is illegal.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    imm,
  output imm_fmt_e           fmt,
  output logic               illegal
);

  logic [INSTR_W-1:0] imm32;

  // Build a 32-bit signed immediate, then widen it to XLEN by sign extension
  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    imm     = '0;
    case (instr[OPC_W-1:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
`ifdef IMM_GEN_ZICSR_EN
      OPC_SYSTEM: begin
        if (instr[14]) begin
          fmt = FMT_Z;
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
`endif
      default: begin
        illegal = 1'b1;
      end
    endcase

    // CSR immediates are zero-extended; everything else replicates bit 31
    if (fmt == FMT_Z) begin
      imm = XLEN'(instr[19:15]);
    end else begin
      imm = XLEN'($signed(imm32));
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator stage with valid/ready on both sides and a
// one-entry skid register. Optional CSR decode via IMM_GEN_ZICSR_EN.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output imm_fmt_e           out_fmt,
  output logic               out_illegal,
  output logic [TAG_W-1:0]   out_tag
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  imm_fmt_e        skid_fmt;
  logic            skid_illegal;
  logic [TAG_W-1:0] skid_tag;

  logic            skid_valid_nxt, in_ready_nxt, out_valid_nxt;
  logic [XLEN-1:0] skid_imm_nxt, out_imm_nxt;
  imm_fmt_e        skid_fmt_nxt, out_fmt_nxt;
  logic            skid_illegal_nxt, out_illegal_nxt;
  logic [TAG_W-1:0] skid_tag_nxt, out_tag_nxt;

  logic accept, out_free;

  // Next-state for output register, skid entry and registered in_ready
  always_comb begin
    accept           = in_valid && in_ready;
    out_free         = !out_valid || out_ready;
    skid_valid_nxt   = skid_valid;
    skid_imm_nxt     = skid_imm;
    skid_fmt_nxt     = skid_fmt;
    skid_illegal_nxt = skid_illegal;
    skid_tag_nxt     = skid_tag;
    out_valid_nxt    = out_valid;
    out_imm_nxt      = out_imm;
    out_fmt_nxt      = out_fmt;
    out_illegal_nxt  = out_illegal;
    out_tag_nxt      = out_tag;

    if (skid_valid) begin
      // in_ready is low here, so the only movement is skid -> output
      if (out_ready) begin
        out_imm_nxt     = skid_imm;
        out_fmt_nxt     = skid_fmt;
        out_illegal_nxt = skid_illegal;
        out_tag_nxt     = skid_tag;
        skid_valid_nxt  = 1'b0;
      end
    end else if (accept) begin
      if (out_free) begin
        out_valid_nxt   = 1'b1;
        out_imm_nxt     = dec_imm;
        out_fmt_nxt     = dec_fmt;
        out_illegal_nxt = dec_illegal;
        out_tag_nxt     = in_tag;
      end else begin
        skid_valid_nxt   = 1'b1;
        skid_imm_nxt     = dec_imm;
        skid_fmt_nxt     = dec_fmt;
        skid_illegal_nxt = dec_illegal;
        skid_tag_nxt     = in_tag;
      end
    end else if (out_ready) begin
      out_valid_nxt = 1'b0;
    end

    in_ready_nxt = !skid_valid_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_fmt      <= FMT_NONE;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
    end else begin
      in_ready     <= in_ready_nxt;
      out_valid    <= out_valid_nxt;
      out_imm      <= out_imm_nxt;
      out_fmt      <= out_fmt_nxt;
      out_illegal  <= out_illegal_nxt;
      out_tag      <= out_tag_nxt;
      skid_valid   <= skid_valid_nxt;
      skid_imm     <= skid_imm_nxt;
      skid_fmt     <= skid_fmt_nxt;
      skid_illegal <= skid_illegal_nxt;
      skid_tag     <= skid_tag_nxt;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64 instances).
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  localparam int unsigned TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready, out_valid, out_illegal;
  logic [31:0]      out_imm;
  imm_fmt_e         out_fmt;
  logic [TAG_W-1:0] out_tag;

  logic             in_ready64, out_valid64, out_illegal64;
  logic [63:0]      out_imm64;
  imm_fmt_e         out_fmt64;
  logic [TAG_W-1:0] out_tag64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: instruction, expected format, 32-bit imm, 64-bit imm, illegal
  logic [31:0] vec_instr [8];
  logic [2:0]  vec_fmt   [8];
  logic [31:0] vec_imm   [8];
  logic [63:0] vec_imm64 [8];
  logic        vec_ill   [8];

  logic [TAG_W-1:0] hold_tag;
  logic [31:0]      hold_imm;
  logic             hs_in, hs_out, stalled;
  int               sent, rcvd;

  initial begin
    vec_instr[0] = 32'hFFFFFFA3; vec_fmt[0] = FMT_S; vec_imm[0] = 32'hFFFFFFFF; vec_imm64[0] = 64'hFFFFFFFFFFFFFFFF; vec_ill[0] = 1'b0;
    vec_instr[1] = 32'hC0151063; vec_fmt[1] = FMT_B; vec_imm[1] = 32'hFFFFF400; vec_imm64[1] = 64'hFFFFFFFFFFFFF400; vec_ill[1] = 1'b0;
    vec_instr[2] = 32'h123450B7; vec_fmt[2] = FMT_U; vec_imm[2] = 32'h12345000; vec_imm64[2] = 64'h0000000012345000; vec_ill[2] = 1'b0;
    vec_instr[3] = 32'hFFDFF06F; vec_fmt[3] = FMT_J; vec_imm[3] = 32'hFFFFFFFC; vec_imm64[3] = 64'hFFFFFFFFFFFFFFFC; vec_ill[3] = 1'b0;
    vec_instr[4] = 32'h800000B7; vec_fmt[4] = FMT_U; vec_imm[4] = 32'h80000000; vec_imm64[4] = 64'hFFFFFFFF80000000; vec_ill[4] = 1'b0;
    vec_instr[5] = 32'h0000007F; vec_fmt[5] = FMT_NONE; vec_imm[5] = 32'h0; vec_imm64[5] = 64'h0; vec_ill[5] = 1'b1;
    vec_instr[6] = 32'h00000033; vec_fmt[6] = FMT_R; vec_imm[6] = 32'h0; vec_imm64[6] = 64'h0; vec_ill[6] = 1'b0;
    vec_instr[7] = 32'h0002D073;
`ifdef IMM_GEN_ZICSR_EN
    vec_fmt[7] = FMT_Z; vec_imm[7] = 32'h5; vec_imm64[7] = 64'h5; vec_ill[7] = 1'b0;
`else
    vec_fmt[7] = FMT_NONE; vec_imm[7] = 32'h0; vec_imm64[7] = 64'h0; vec_ill[7] = 1'b1;
`endif

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_fmt", out_fmt, FMT_NONE);
    check("rst_out_illegal", out_illegal, 0);
    check("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    tick();

    // Single LOAD word, one-cycle latency
    in_valid = 1'b1; in_instr = 32'h00100003; in_tag = 8'h01;
    tick();
    in_valid = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_fmt", out_fmt, FMT_I);
    check("single_imm", out_imm, 32'h00000001);
    check("single_illegal", out_illegal, 0);
    check("single_tag", out_tag, 8'h01);
    tick();
    check("single_drain_valid", out_valid, 0);

    // Back-to-back stream of all vectors with out_ready high
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = vec_instr[i]; in_tag = 8'(8'h10 + i);
      tick();
      check($sformatf("b2b%0d_valid", i), out_valid, 1);
      check($sformatf("b2b%0d_fmt", i), out_fmt, vec_fmt[i]);
      check($sformatf("b2b%0d_imm", i), out_imm, vec_imm[i]);
      check($sformatf("b2b%0d_illegal", i), out_illegal, vec_ill[i]);
      check($sformatf("b2b%0d_tag", i), out_tag, 8'(8'h10 + i));
      check($sformatf("b2b%0d_imm64", i), out_imm64, vec_imm64[i]);
      check($sformatf("b2b%0d_in_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check("b2b_drain_valid", out_valid, 0);

    // Backpressure: tags 1..6, out_ready low for cycles 2..4; OP-IMM imm equals tag
    sent = 1; rcvd = 1;
    for (int cyc = 0; cyc < 40 && rcvd <= 6; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (sent <= 6);
      in_instr  = {12'(sent), 20'h00013};
      in_tag    = 8'(sent);
      hs_in     = in_valid && in_ready;
      hs_out    = out_valid && out_ready;
      stalled   = out_valid && !out_ready;
      hold_tag  = out_tag;
      hold_imm  = out_imm;
      if (hs_out) begin
        check("bp_tag_order", out_tag, 64'(rcvd));
        check("bp_imm", out_imm, 64'(rcvd));
        rcvd++;
      end
      tick();
      if (hs_in) sent++;
      if (stalled) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_tag", out_tag, hold_tag);
        check("bp_hold_imm", out_imm, hold_imm);
        if (hs_in) check("bp_in_ready_drop", in_ready, 0);
      end
    end
    check("bp_count", rcvd, 7);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_drain_valid", out_valid, 0);

    // Fill output and skid, then reset mid-cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100003; in_tag = 8'h21;
    tick();
    in_tag = 8'h22;
    tick();
    in_valid = 1'b0;
    check("pre_rst_in_ready", in_ready, 0);
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_tag", out_tag, 0);
    check("mid_rst_imm", out_imm, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00500013; in_tag = 8'h33;
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_tag", out_tag, 8'h33);
    check("post_rst_imm", out_imm, 32'h5);
    tick();
    check("post_rst_drain", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
